// File: rtl/vdp_irq_gen.sv
// VDP raster counters, line/frame interrupt flags, status byte and port 0x7E V counter; optional VDP_SPRITE_FLAGS_EN adds sprite OVR/COL flags.
// Latency: flags set on the line-start edge; INT_L and stat_reg_out are combinational views of the registered flags (low the cycle after the set edge).
// Backpressure: none; free-running counters, stat_rd is a one-cycle clear pulse and a simultaneous set wins.
module vdp_irq_gen #(
    parameter int H_TOTAL  = 228,
    parameter int V_TOTAL  = 262,
    parameter int V_ACTIVE = 192
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       line_irq_en,
    input  logic       frame_irq_en,
    input  logic [7:0] line_reload,
    input  logic       stat_rd,
`ifdef VDP_SPRITE_FLAGS_EN
    input  logic       spr_ovr,
    input  logic       spr_col,
`endif
    output logic       INT_L,
    output logic [7:0] stat_reg_out,
    output logic [8:0] h_count,
    output logic [8:0] v_count,
    output logic [7:0] v_counter_out
);

    logic       line_start;
    logic [8:0] nv;
    logic [7:0] line_ctr;
    logic       line_set;
    logic       frame_set;
    logic       f_flag;
    logic       line_pend;
    logic       ovr_flag;
    logic       col_flag;

    assign line_start = (h_count == 9'(H_TOTAL - 1));
    assign nv         = (v_count == 9'(V_TOTAL - 1)) ? 9'd0 : v_count + 9'd1;
    assign frame_set  = line_start && (nv == 9'(V_ACTIVE));
    assign line_set   = line_start && (nv <= 9'(V_ACTIVE)) && (line_ctr == 8'd0);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            h_count <= 9'd0;
            v_count <= 9'd0;
        end else if (line_start) begin
            h_count <= 9'd0;
            v_count <= nv;
        end else begin
            h_count <= h_count + 9'd1;
        end
    end

    // Blanking lines keep reloading, so the first active line always starts from a fresh count.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            line_ctr <= 8'hFF;
        end else if (line_start) begin
            if ((nv > 9'(V_ACTIVE)) || (line_ctr == 8'd0)) begin
                line_ctr <= line_reload;
            end else begin
                line_ctr <= line_ctr - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            f_flag    <= 1'b0;
            line_pend <= 1'b0;
        end else begin
            f_flag    <= frame_set | (f_flag & ~stat_rd);
            line_pend <= line_set | (line_pend & ~stat_rd);
        end
    end

`ifdef VDP_SPRITE_FLAGS_EN
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ovr_flag <= 1'b0;
            col_flag <= 1'b0;
        end else begin
            ovr_flag <= spr_ovr | (ovr_flag & ~stat_rd);
            col_flag <= spr_col | (col_flag & ~stat_rd);
        end
    end
`else
    assign ovr_flag = 1'b0;
    assign col_flag = 1'b0;
`endif

    assign stat_reg_out = {f_flag, ovr_flag, col_flag, 5'b0_0000};
    assign INT_L        = ~((f_flag & frame_irq_en) | (line_pend & line_irq_en));

    // Lines past 0xDA fold back by 6 so the NTSC count reads 0xD5..0xFF at the bottom.
    assign v_counter_out = (v_count <= 9'h0DA) ? v_count[7:0] : (v_count[7:0] - 8'd6);

endmodule

// File: tb/tb_vdp_irq_gen.sv
// Scoreboarded bench for vdp_irq_gen: a raster-position reference model pushes expected outputs, a monitor pops and compares.
module tb_vdp_irq_gen;

    localparam int HT = 228;
    localparam int VT = 262;
    localparam int VA = 192;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       line_irq_en, frame_irq_en, stat_rd;
    logic [7:0] line_reload;
    logic       INT_L;
    logic [7:0] stat_reg_out, v_counter_out;
    logic [8:0] h_count, v_count;
`ifdef VDP_SPRITE_FLAGS_EN
    logic       spr_ovr, spr_col;
`endif

    vdp_irq_gen dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .line_irq_en  (line_irq_en),
        .frame_irq_en (frame_irq_en),
        .line_reload  (line_reload),
        .stat_rd      (stat_rd),
`ifdef VDP_SPRITE_FLAGS_EN
        .spr_ovr      (spr_ovr),
        .spr_col      (spr_col),
`endif
        .INT_L        (INT_L),
        .stat_reg_out (stat_reg_out),
        .h_count      (h_count),
        .v_count      (v_count),
        .v_counter_out(v_counter_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         h;
        int         v;
        int         fr;
        logic [7:0] vc;
        logic [7:0] stat;
        logic       il;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference model: position is derived from the number of clock edges since reset release.
    int   k = 0;
    int   m_ctr = 255;
    logic m_f = 0, m_p = 0, m_o = 0, m_c = 0;

    always @(posedge clk) begin
        exp_t e;
        int   h, ln, nv;
        logic set_f, set_p;
        if (!reset_L) begin
            k = 0; m_ctr = 255; m_f = 0; m_p = 0; m_o = 0; m_c = 0;
        end else begin
            h     = k % HT;
            ln    = k / HT;
            nv    = (ln + 1) % VT;
            set_f = (h == HT - 1) && (nv == VA);
            set_p = 1'b0;
            if (h == HT - 1) begin
                if (nv > VA) m_ctr = line_reload;
                else if (m_ctr == 0) begin
                    set_p = 1'b1;
                    m_ctr = line_reload;
                end else m_ctr = m_ctr - 1;
            end
            m_f = set_f || (m_f && !stat_rd);
            m_p = set_p || (m_p && !stat_rd);
`ifdef VDP_SPRITE_FLAGS_EN
            m_o = spr_ovr || (m_o && !stat_rd);
            m_c = spr_col || (m_c && !stat_rd);
`endif
            k++;
        end
        e.h    = k % HT;
        e.v    = (k / HT) % VT;
        e.fr   = k / FRAME;
        e.vc   = (e.v <= 218) ? 8'(e.v) : 8'(e.v - 6);
        e.stat = {m_f, m_o, m_c, 5'b0};
        e.il   = !((m_f && frame_irq_en) || (m_p && line_irq_en));
        exp_q.push_back(e);
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("h_count", 32'(h_count), 32'(e.h));
            chk("v_count", 32'(v_count), 32'(e.v));
            chk("v_counter_out", 32'(v_counter_out), 32'(e.vc));
            chk("stat_reg_out", 32'(stat_reg_out), 32'(e.stat));
            chk("INT_L", 32'(INT_L), 32'(e.il));
            if (e.h == 3 && e.v == 218) chk("vcnt_218", 32'(v_counter_out), 32'h0DA);
            if (e.h == 3 && e.v == 219) chk("vcnt_219", 32'(v_counter_out), 32'h0D5);
            if (e.h == 3 && e.v == 261) chk("vcnt_261", 32'(v_counter_out), 32'h0FF);
            if (e.fr == 0 && e.h == 0 && e.v < 200) chk("int_idle_frame0", 32'(INT_L), 32'h1);
            if (e.fr == 0 && e.h == 0 && e.v == VA) chk("frame_flag_survives_read", 32'(stat_reg_out), 32'h80);
            if (e.fr == 0 && e.h == 11 && e.v == 200) chk("int_on_enable_raise", 32'(INT_L), 32'h0);
            if (e.fr == 0 && e.h == 0 && e.v == 205) chk("stat_during_read", 32'(stat_reg_out), 32'h80);
            if (e.fr == 0 && e.h == 1 && e.v == 205) chk("int_after_read", 32'(INT_L), 32'h1);
            if (e.fr == 0 && e.h == 1 && e.v == 205) chk("stat_after_read", 32'(stat_reg_out), 32'h00);
        end
    end

    initial begin
        int h, v, fr;
        reset_L = 1'b0; line_irq_en = 1'b0; frame_irq_en = 1'b0; stat_rd = 1'b0; line_reload = 8'd3;
`ifdef VDP_SPRITE_FLAGS_EN
        spr_ovr = 1'b0; spr_col = 1'b0;
`endif
        #2;
        chk("reset_int", 32'(INT_L), 32'h1);
        chk("reset_stat", 32'(stat_reg_out), 32'h0);
        repeat (3) @(negedge clk);
        reset_L = 1'b1;
        while (k < FRAME + 25000) begin
            @(negedge clk);
            h  = k % HT;
            v  = (k / HT) % VT;
            fr = k / FRAME;
            stat_rd = 1'b0;
`ifdef VDP_SPRITE_FLAGS_EN
            spr_ovr = 1'b0; spr_col = 1'b0;
`endif
            if (fr == 0) begin
                if (v == VA - 1 && h == HT - 1) stat_rd = 1'b1;
                if (v == 200 && h == 10) frame_irq_en = 1'b1;
                if (v == 205 && h == 0) stat_rd = 1'b1;
                if (v == 230 && h == 0) line_irq_en = 1'b1;
            end else begin
                if (h == HT - 1 && $urandom_range(3) == 0) stat_rd = 1'b1;
                else if ($urandom_range(199) == 0) stat_rd = 1'b1;
                if ($urandom_range(999) == 0) frame_irq_en = ~frame_irq_en;
                if ($urandom_range(999) == 0) line_irq_en = ~line_irq_en;
                if (h == 100 && v % 16 == 15) line_reload = 8'($urandom_range(6));
`ifdef VDP_SPRITE_FLAGS_EN
                spr_ovr = ($urandom_range(299) == 0);
                spr_col = ($urandom_range(299) == 0);
`endif
            end
        end
        // Mid-line asynchronous reset
        @(negedge clk);
        stat_rd = 1'b0;
        frame_irq_en = 1'b1;
        line_irq_en = 1'b1;
        #3 reset_L = 1'b0;
        #1;
        chk("arst_h", 32'(h_count), 32'h0);
        chk("arst_v", 32'(v_count), 32'h0);
        chk("arst_int", 32'(INT_L), 32'h1);
        chk("arst_stat", 32'(stat_reg_out), 32'h0);
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        repeat (600) begin
            @(negedge clk);
            stat_rd = ($urandom_range(49) == 0);
        end
        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
